// File: rtl/weight_fetch_ctrl_if.sv
// Weight fetch bus bundle: GLB read port plus the horizontal weight buffer
// load port. The controller uses the master modport, and the GLB/buffer side
// uses the slave modport.
interface weight_fetch_ctrl_if;
  logic        glb_re;
  logic [31:0] glb_addr;
  logic        glb_gnt;
  logic [31:0] glb_rdata;
  logic        change_weight_f;
  logic        ready_w;
  logic        valid_w;
  logic [31:0] weight_in;

  modport master (
    output glb_re, glb_addr, change_weight_f, ready_w, valid_w, weight_in,
    input  glb_gnt, glb_rdata
  );

  modport slave (
    input  glb_re, glb_addr, change_weight_f, ready_w, valid_w, weight_in,
    output glb_gnt, glb_rdata
  );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller. Streams one layer's weights from the GLB into the
// horizontal weight buffer. Reset is synchronous and active-high.
// Optional macro WFC_STALL_CNT_EN enables a saturating counter of FETCH cycles
// that had no grant. Without this macro, stall_cnt_o reads 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; latches the load size and base address
// S_CLEAR | one-cycle change_weight_f pulse to flush the weight buffer
// S_FETCH | issuing GLB reads until the last one is granted
// S_DRAIN | last read data returns as the final valid_w beat
// S_DONE  | one-cycle done pulse, then back to idle
module weight_fetch_ctrl (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [1:0]                 pass_layer_type_i,
  input  logic [5:0]                 row_en_i,
  input  logic [4:0]                 col_in_i,
  input  logic [31:0]                base_addr_i,
  weight_fetch_ctrl_if.master        bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [15:0]                stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] LT_PW = 2'd0;
  localparam logic [1:0] LT_DW = 2'd1;

  state_t      state_q, state_d;
  logic [8:0]  words_q, words_d;   // reads still to be granted (down-counter)
  logic [31:0] addr_q, addr_d;     // address of the next read to issue
  logic        beat_q, beat_d;     // a read was granted last cycle
  logic [8:0]  words_per_row;
  logic [8:0]  total_words;

  // The low two bits of col_in do not affect the words-per-row count
  logic unused_col_bits;
  assign unused_col_bits = ^col_in_i[1:0];

  // Load size from the live inputs; it is captured only when start is accepted
  always_comb begin
    words_per_row = {6'd0, col_in_i[4:2]} + 9'd1;
    total_words   = 9'd0;
    case (pass_layer_type_i)
      LT_PW:   total_words = {3'd0, row_en_i} * words_per_row;
      LT_DW:   total_words = {3'd0, row_en_i};
      default: total_words = 9'd0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      words_q <= 9'd0;
      addr_q  <= 32'd0;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  // Next state, counters and bus outputs
  always_comb begin
    state_d             = state_q;
    words_d             = words_q;
    addr_d              = addr_q;
    beat_d              = 1'b0;
    bus.glb_re          = 1'b0;
    bus.glb_addr        = 32'd0;
    bus.change_weight_f = 1'b0;
    bus.ready_w         = 1'b0;
    busy_o              = 1'b1;
    done_o              = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          words_d = total_words;
          addr_d  = base_addr_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bus.change_weight_f = 1'b1;
        state_d = (words_q == 9'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        bus.ready_w  = 1'b1;
        bus.glb_re   = 1'b1;
        bus.glb_addr = addr_q;
        if (bus.glb_gnt) begin
          beat_d  = 1'b1;
          addr_d  = addr_q + 32'd4;
          words_d = words_q - 9'd1;
          if (words_q == 9'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.ready_w = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // GLB data is valid the cycle after the grant, so it is forwarded directly
  assign bus.valid_w   = beat_q;
  assign bus.weight_in = beat_q ? bus.glb_rdata : 32'd0;

`ifdef WFC_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count ungranted FETCH cycles, restarting at each accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else if ((state_q == S_IDLE) && start_i) begin
      stall_q <= 16'd0;
    end else if ((state_q == S_FETCH) && !bus.glb_gnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule
